// File: rtl/hdlc_rx_if.sv
// Byte-stream bundle between the HDLC receive controller (master) and the packet layer (slave).
// The master drives the received bytes and frame status; the slave drives the serial input and outReady.
interface hdlc_rx_if #(
    parameter int LEN_W = 8
);
    logic             serEn;
    logic             serIn;
    logic [7:0]       outByte;
    logic             outValid;
    logic             outReady;
    logic             outFirst;
    logic             frameEnd;
    logic             frameOk;
    logic [LEN_W-1:0] frameLen;
    logic             abortErr;
    logic             inFrame;

    modport master (
        input  serEn,
        input  serIn,
        input  outReady,
        output outByte,
        output outValid,
        output outFirst,
        output frameEnd,
        output frameOk,
        output frameLen,
        output abortErr,
        output inFrame
    );

    modport slave (
        output serEn,
        output serIn,
        output outReady,
        input  outByte,
        input  outValid,
        input  outFirst,
        input  frameEnd,
        input  frameOk,
        input  frameLen,
        input  abortErr,
        input  inFrame
    );
endinterface

// File: rtl/hdlc_rx_ctrl.sv
// HDLC receive controller: flag hunt, zero destuffing, LSB-first byte assembly,
// single-entry valid/ready output register and per-frame status reporting.
module hdlc_rx_ctrl #(
    parameter int LEN_W     = 8,
    parameter int MIN_BYTES = 2
) (
    input logic       clk,
    input logic       rst,
    hdlc_rx_if.master bus
);
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        RX   = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_BYTES);

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        if (v == LEN_MAX) begin
            sat_inc = LEN_MAX;
        end else begin
            sat_inc = v + {{(LEN_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       ones_q, ones_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       sh_q, sh_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_valid_q, out_valid_d;
    logic             out_first_q, out_first_d;
    logic             frame_end_q, frame_end_d;
    logic             frame_ok_q, frame_ok_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic             abort_q, abort_d;
    logic             in_frame_q, in_frame_d;

    logic             flag_s;
    logic             seventh_s;
    logic             data_bit_s;
    logic             room_s;

    // Classify the strobed bit from the run of ones that precedes it.
    always_comb begin
        flag_s     = 1'b0;
        seventh_s  = 1'b0;
        data_bit_s = 1'b0;
        ones_d     = ones_q;
        if (bus.serEn) begin
            if (bus.serIn) begin
                if (ones_q >= 3'd6) begin
                    seventh_s = 1'b1;
                    ones_d    = 3'd7;
                end else begin
                    data_bit_s = (state_q != HUNT);
                    ones_d     = ones_q + 3'd1;
                end
            end else begin
                ones_d = 3'd0;
                case (ones_q)
                    3'd5:    data_bit_s = 1'b0;
                    3'd6:    flag_s     = 1'b1;
                    default: data_bit_s = (state_q != HUNT);
                endcase
            end
        end else begin
            ones_d = ones_q;
        end
    end

    assign room_s = ~out_valid_q | bus.outReady;

    // Frame state, byte assembly, output register and status pulses.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        ovf_d       = ovf_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q & ~bus.outReady;
        out_first_d = out_first_q;
        frame_end_d = 1'b0;
        frame_ok_d  = frame_ok_q;
        frame_len_d = frame_len_q;
        abort_d     = 1'b0;
        in_frame_d  = in_frame_q;

        if (seventh_s) begin
            state_d    = HUNT;
            bit_cnt_d  = 3'd0;
            abort_d    = (state_q == RX);
            in_frame_d = 1'b0;
        end else if (flag_s) begin
            if (state_q == RX) begin
                frame_end_d = 1'b1;
                frame_ok_d  = (bit_cnt_q == 3'd7) & ~ovf_q & (frame_len_q >= LEN_MIN);
            end else begin
                frame_end_d = 1'b0;
            end
            state_d    = SYNC;
            bit_cnt_d  = 3'd0;
            ovf_d      = 1'b0;
            in_frame_d = 1'b0;
        end else if (data_bit_s) begin
            sh_d[bit_cnt_q] = bus.serIn;
            if (bit_cnt_q != 3'd7) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end else begin
                bit_cnt_d = 3'd0;
                if (room_s) begin
                    out_byte_d  = sh_d;
                    out_valid_d = 1'b1;
                    out_first_d = (state_q == SYNC);
                    state_d     = RX;
                    in_frame_d  = 1'b1;
                    if (state_q == SYNC) begin
                        frame_len_d = {{(LEN_W-1){1'b0}}, 1'b1};
                    end else begin
                        frame_len_d = sat_inc(frame_len_q);
                    end
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            ones_q      <= 3'd0;
            bit_cnt_q   <= 3'd0;
            sh_q        <= 8'd0;
            ovf_q       <= 1'b0;
            out_byte_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            frame_end_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_len_q <= {LEN_W{1'b0}};
            abort_q     <= 1'b0;
            in_frame_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            ovf_q       <= ovf_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            frame_end_q <= frame_end_d;
            frame_ok_q  <= frame_ok_d;
            frame_len_q <= frame_len_d;
            abort_q     <= abort_d;
            in_frame_q  <= in_frame_d;
        end
    end

    assign bus.outByte  = out_byte_q;
    assign bus.outValid = out_valid_q;
    assign bus.outFirst = out_first_q;
    assign bus.frameEnd = frame_end_q;
    assign bus.frameOk  = frame_ok_q;
    assign bus.frameLen = frame_len_q;
    assign bus.abortErr = abort_q;
    assign bus.inFrame  = in_frame_q;
endmodule

// File: tb/tb_hdlc_rx_ctrl.sv
// Bench for hdlc_rx_ctrl: HDLC-encoded streams (directed and random) checked cycle by cycle
// against a behavioural receiver model, plus frame-level expectations for the directed cases.
module tb_hdlc_rx_ctrl;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst;

    hdlc_rx_if #(.LEN_W(LEN_W)) bus ();

    hdlc_rx_ctrl #(.LEN_W(LEN_W), .MIN_BYTES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural receiver: run length of ones, sync/framing flags, bits gathered so far.
    int         m_run;
    bit         m_synced;
    bit         m_framing;
    bit         m_ovf;
    logic [7:0] m_bits;
    int         m_nbits;
    logic [7:0] e_byte;
    bit         e_valid, e_first, e_end, e_ok, e_abort;
    int         e_len;

    task automatic model_reset();
        m_run = 0; m_synced = 1'b0; m_framing = 1'b0; m_ovf = 1'b0;
        m_bits = 8'd0; m_nbits = 0;
        e_byte = 8'd0; e_valid = 1'b0; e_first = 1'b0; e_end = 1'b0;
        e_ok = 1'b0; e_abort = 1'b0; e_len = 0;
    endtask

    task automatic model_step(input bit en, input bit b, input bit rdy);
        bit room;
        bit data;
        room = !e_valid || rdy;
        if (e_valid && rdy) e_valid = 1'b0;
        e_end = 1'b0; e_abort = 1'b0; data = 1'b0;
        if (en) begin
            if (b) begin
                m_run = (m_run >= 7) ? 7 : m_run + 1;
                if (m_run == 7) begin
                    if (m_framing) e_abort = 1'b1;
                    m_framing = 1'b0; m_synced = 1'b0; m_nbits = 0;
                end else begin
                    data = m_synced;
                end
            end else begin
                if (m_run == 6) begin
                    if (m_framing) begin
                        e_end = 1'b1;
                        e_ok  = (m_nbits == 7) && !m_ovf && (e_len >= 2);
                    end
                    m_framing = 1'b0; m_synced = 1'b1; m_nbits = 0; m_ovf = 1'b0;
                end else if (m_run != 5) begin
                    data = m_synced;
                end
                m_run = 0;
            end
        end
        if (data) begin
            m_bits[m_nbits] = b;
            m_nbits++;
            if (m_nbits == 8) begin
                m_nbits = 0;
                if (room) begin
                    e_byte  = m_bits;
                    e_valid = 1'b1;
                    e_first = !m_framing;
                    e_len   = !m_framing ? 1 : ((e_len >= 255) ? 255 : e_len + 1);
                    m_framing = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    // Observations of the DUT used for frame-level checks.
    int         obs_end, obs_abort, obs_len;
    bit         obs_ok;
    logic [7:0] acc_q[$];
    bit         accf_q[$];

    task automatic clr_obs();
        obs_end = 0; obs_abort = 0; obs_len = 0; obs_ok = 1'b0;
        acc_q.delete(); accf_q.delete();
    endtask

    task automatic cycle(input bit en, input bit b, input bit rdy);
        bus.serEn = en; bus.serIn = b; bus.outReady = rdy;
        if (bus.outValid && rdy) begin
            acc_q.push_back(bus.outByte);
            accf_q.push_back(bus.outFirst);
        end
        model_step(en, b, rdy);
        @(posedge clk);
        #1;
        chk("outValid", 32'(bus.outValid), 32'(e_valid));
        if (e_valid) begin
            chk("outByte", 32'(bus.outByte), 32'(e_byte));
            chk("outFirst", 32'(bus.outFirst), 32'(e_first));
        end
        chk("frameEnd", 32'(bus.frameEnd), 32'(e_end));
        if (e_end) chk("frameOk", 32'(bus.frameOk), 32'(e_ok));
        chk("frameLen", 32'(bus.frameLen), e_len);
        chk("abortErr", 32'(bus.abortErr), 32'(e_abort));
        chk("inFrame", 32'(bus.inFrame), 32'(m_framing));
        if (bus.frameEnd) begin
            obs_end++; obs_ok = bus.frameOk; obs_len = int'(bus.frameLen);
        end
        if (bus.abortErr) obs_abort++;
    endtask

    // Transmit-side encoder producing the serial bit stream.
    bit txq[$];
    int tx_ones;

    task automatic push_flag();
        txq.push_back(1'b0);
        for (int i = 0; i < 6; i++) txq.push_back(1'b1);
        txq.push_back(1'b0);
        tx_ones = 0;
    endtask

    task automatic push_data(input bit b);
        txq.push_back(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 5) begin
                txq.push_back(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) push_data(v[i]);
    endtask

    task automatic push_raw(input bit b, input int n);
        for (int i = 0; i < n; i++) txq.push_back(b);
    endtask

    // en_mode: 0 every cycle, 1 one cycle in three, 2 random
    task automatic run_stream(input int en_mode, input int rdy_pct);
        int ph;
        ph = 0;
        while (txq.size() > 0) begin
            bit en, b, rdy;
            case (en_mode)
                0:       en = 1'b1;
                1:       en = (ph % 3 == 0);
                default: en = ($urandom_range(0, 99) < 70);
            endcase
            ph++;
            rdy = ($urandom_range(0, 99) < rdy_pct);
            if (en) b = txq.pop_front();
            else    b = 1'($urandom_range(0, 1));
            cycle(en, b, rdy);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)), rdy);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_outByte"}, 32'(bus.outByte), 32'd0);
        chk({pfx, "_outValid"}, 32'(bus.outValid), 32'd0);
        chk({pfx, "_outFirst"}, 32'(bus.outFirst), 32'd0);
        chk({pfx, "_frameEnd"}, 32'(bus.frameEnd), 32'd0);
        chk({pfx, "_frameOk"}, 32'(bus.frameOk), 32'd0);
        chk({pfx, "_frameLen"}, 32'(bus.frameLen), 32'd0);
        chk({pfx, "_abortErr"}, 32'(bus.abortErr), 32'd0);
        chk({pfx, "_inFrame"}, 32'(bus.inFrame), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        bus.serEn = 1'b0; bus.serIn = 1'b0; bus.outReady = 1'b0;
        model_reset(); clr_obs(); tx_ones = 0;
        #12;
        chk_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // T1: reset in the middle of a frame, then a clean two-byte frame
        push_flag(); push_byte(8'hA5); push_data(1'b1); push_data(1'b0); push_data(1'b1);
        run_stream(0, 100);
        #1 rst = 1'b0;
        #1 chk_zero("t1_rst");
        rst = 1'b1;
        model_reset(); clr_obs(); txq.delete(); tx_ones = 0;
        push_flag(); push_byte(8'hA5); push_byte(8'h3C); push_flag();
        run_stream(0, 100); idle(3, 1'b1);
        chk("t1_ends", obs_end, 1); chk("t1_ok", 32'(obs_ok), 1); chk("t1_len", obs_len, 2);
        chk("t1_nbytes", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            chk("t1_b0", 32'(acc_q[0]), 32'hA5); chk("t1_b1", 32'(acc_q[1]), 32'h3C);
            chk("t1_f0", 32'(accf_q[0]), 1); chk("t1_f1", 32'(accf_q[1]), 0);
        end

        // T2: single stuffed 0xFF byte, too short to be ok
        clr_obs();
        push_flag(); push_byte(8'hFF); push_flag();
        run_stream(0, 100); idle(3, 1'b1);
        chk("t2_ends", obs_end, 1); chk("t2_ok", 32'(obs_ok), 0); chk("t2_len", obs_len, 1);
        chk("t2_nbytes", acc_q.size(), 1);
        if (acc_q.size() == 1) chk("t2_b0", 32'(acc_q[0]), 32'hFF);

        // T3: two bytes then an abort sequence
        clr_obs();
        push_flag(); push_byte(8'h7E); push_byte(8'h01); push_raw(1'b1, 8);
        run_stream(0, 100); idle(3, 1'b1);
        chk("t3_aborts", obs_abort, 1); chk("t3_ends", obs_end, 0);
        chk("t3_inFrame", 32'(bus.inFrame), 0);
        chk("t3_nbytes", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            chk("t3_b0", 32'(acc_q[0]), 32'h7E); chk("t3_b1", 32'(acc_q[1]), 32'h01);
        end

        // T4: frame closed with a partial byte outstanding
        clr_obs();
        push_flag(); push_byte(8'h5A);
        push_data(1'b0); push_data(1'b1); push_data(1'b0); push_data(1'b1);
        push_flag();
        run_stream(0, 100); idle(3, 1'b1);
        chk("t4_ends", obs_end, 1); chk("t4_ok", 32'(obs_ok), 0);
        if (acc_q.size() > 0) chk("t4_b0", 32'(acc_q[0]), 32'h5A);
        else chk("t4_nbytes", acc_q.size(), 1);

        // T5: consumer stalled for a whole frame
        clr_obs();
        push_flag(); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_flag();
        run_stream(0, 0);
        chk("t5_ends", obs_end, 1); chk("t5_ok", 32'(obs_ok), 0); chk("t5_len", obs_len, 1);
        chk("t5_held", acc_q.size(), 0);
        idle(4, 1'b1);
        chk("t5_nbytes", acc_q.size(), 1);
        if (acc_q.size() == 1) chk("t5_b0", 32'(acc_q[0]), 32'h11);

        // T6: repeated and shared flags, sparse bit strobes
        clr_obs();
        push_flag(); push_raw(1'b1, 6); push_raw(1'b0, 1); push_flag();
        push_byte(8'h55); push_byte(8'hAA); push_flag();
        run_stream(1, 100); idle(3, 1'b1);
        chk("t6_ends", obs_end, 1); chk("t6_ok", 32'(obs_ok), 1); chk("t6_len", obs_len, 2);
        chk("t6_nbytes", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            chk("t6_b0", 32'(acc_q[0]), 32'h55); chk("t6_b1", 32'(acc_q[1]), 32'hAA);
            chk("t6_f0", 32'(accf_q[0]), 1);
        end

        // Length counter saturation on a long frame
        clr_obs();
        push_flag();
        for (int i = 0; i < 260; i++) push_byte(8'(i * 7));
        push_flag();
        run_stream(0, 100); idle(3, 1'b1);
        chk("sat_ends", obs_end, 1); chk("sat_len", obs_len, 255); chk("sat_ok", 32'(obs_ok), 1);
        chk("sat_nbytes", acc_q.size(), 260);

        // Random frames: varied payloads, residue, aborts, garbage, strobe and ready patterns
        for (int f = 0; f < 60; f++) begin
            int kind, nb, pct_sel;
            kind = $urandom_range(0, 9);
            nb   = $urandom_range(0, 5);
            push_flag();
            for (int k = 0; k < nb; k++) begin
                case ($urandom_range(0, 3))
                    0:       push_byte(8'hFF);
                    1:       push_byte(8'h7E);
                    2:       push_byte(8'h3F);
                    default: push_byte(8'($urandom_range(0, 255)));
                endcase
            end
            case (kind)
                0: begin
                    for (int k = 0; k < $urandom_range(1, 7); k++) push_data(1'($urandom_range(0, 1)));
                    push_flag();
                end
                1:       push_raw(1'b1, $urandom_range(7, 9));
                2:       for (int k = 0; k < 12; k++) txq.push_back(1'($urandom_range(0, 1)));
                default: push_flag();
            endcase
            pct_sel = $urandom_range(0, 2);
            run_stream($urandom_range(0, 2), (pct_sel == 0) ? 100 : ((pct_sel == 1) ? 60 : 20));
        end
        idle(10, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
